// File: rtl/riscv_pkg.sv
// riscv_pkg: shared integer-pipeline widths and the writeback request record.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small writeback request FIFO with wrap-bit pointers and a combinational head.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    wb_req_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_req;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and long-latency results into one registered
// register-file write per cycle and tracks pending long-latency destinations.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hazard1,
    output logic            hazard2,
    output logic            alu_stall,
    output logic            RegWrite,
    output logic [4:0]      WriteRegister,
    output logic [XLEN-1:0] WriteData
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    wb_req_t head;
    logic full, empty, push, pop, alu_sel;
    logic [SW-1:0] starve_cnt;
    logic [31:0] busy, busy_next;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .push_req('{rd: mem_rd, data: mem_data}),
        .pop(pop),
        .head(head),
        .full(full),
        .empty(empty)
    );
    assign mem_ready = !full;
    assign push      = mem_valid && !full;
    assign alu_stall = starve_cnt == SW'(STARVE_MAX);
    assign pop       = !empty && (alu_stall || !alu_valid);
    assign alu_sel   = !alu_stall && alu_valid;
    assign hazard1   = busy[rs1];
    assign hazard2   = busy[rs2];
    // A same-cycle issue to the register being retired must keep it busy, so set follows clear.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= '0;
            starve_cnt    <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            busy       <= busy_next;
            starve_cnt <= (pop || empty) ? '0 : starve_cnt + 1'b1;
            RegWrite   <= pop ? head.rd != 5'd0 : alu_sel && alu_rd != 5'd0;
            if (pop || alu_sel) begin
                WriteRegister <= pop ? head.rd : alu_rd;
                WriteData     <= pop ? head.data : alu_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus checked every cycle against a queue-based
// model of the writeback rules, plus literal expectations for the key scenarios.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int STARVE_MAX = 4;
    logic clk = 0, rst_n = 0;
    logic alu_valid = 0, mem_valid = 0, iss_valid = 0;
    logic [4:0] alu_rd = 0, mem_rd = 0, iss_rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] alu_data = 0, mem_data = 0;
    logic mem_ready, hazard1, hazard2, alu_stall, RegWrite;
    logic [4:0] WriteRegister;
    logic [31:0] WriteData;
    int checks = 0, failures = 0;

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .hazard1(hazard1), .hazard2(hazard2), .alu_stall(alu_stall),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int m_starve = 0;
    logic [31:0] m_busy = 0;
    logic m_we = 0;
    logic [4:0] m_wa = 0;
    logic [31:0] m_wd = 0;

    // Model: a queue of pending results; what was committed at the last edge is
    // compared here, then the commit for the coming edge is worked out from the inputs.
    always @(negedge clk) begin
        ent_t e;
        bit was_empty, was_full, stall, do_pop;
        if (!rst_n) begin
            q.delete();
            m_starve = 0;
            m_busy = 0;
            m_we = 0;
            m_wa = 0;
            m_wd = 0;
        end
        chk("model_RegWrite", RegWrite, m_we);
        chk("model_WriteRegister", WriteRegister, m_wa);
        chk("model_WriteData", WriteData, m_wd);
        chk("model_mem_ready", mem_ready, q.size() < DEPTH);
        chk("model_alu_stall", alu_stall, m_starve == STARVE_MAX);
        chk("model_hazard1", hazard1, m_busy[rs1]);
        chk("model_hazard2", hazard2, m_busy[rs2]);
        if (rst_n) begin
            was_empty = q.size() == 0;
            was_full = q.size() >= DEPTH;
            stall = m_starve == STARVE_MAX;
            do_pop = !was_empty && (stall || !alu_valid);
            if (do_pop) begin
                e = q.pop_front();
                m_we = e.rd != 0;
                m_wa = e.rd;
                m_wd = e.data;
                m_busy[e.rd] = 1'b0;
            end else if (!stall && alu_valid) begin
                m_we = alu_rd != 0;
                m_wa = alu_rd;
                m_wd = alu_data;
            end else begin
                m_we = 0;
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            m_busy[0] = 1'b0;
            m_starve = (do_pop || was_empty) ? 0 : m_starve + 1;
            if (mem_valid && !was_full) q.push_back('{rd: mem_rd, data: mem_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0;
        mem_valid = 0;
        iss_valid = 0;
    endtask

    initial begin
        int idx;
        bit saw_full, acc;
        ent_t offers[3];
        offers[0] = '{rd: 5'd20, data: 32'hA0};
        offers[1] = '{rd: 5'd21, data: 32'hA1};
        offers[2] = '{rd: 5'd22, data: 32'hA2};

        // reset
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_alu_stall", alu_stall, 0);
        cyc();
        rst_n = 1;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cyc();
        idle();
        @(negedge clk);
        chk("alu_RegWrite", RegWrite, 1);
        chk("alu_WriteRegister", WriteRegister, 5);
        chk("alu_WriteData", WriteData, 32'hDEADBEEF);

        // scoreboard
        cyc();
        iss_valid = 1; iss_rd = 7; rs1 = 7;
        cyc();
        idle();
        @(negedge clk);
        chk("sb_hazard_set", hazard1, 1);
        cyc();
        mem_valid = 1; mem_rd = 7; mem_data = 32'h11;
        cyc();
        idle();
        @(negedge clk);
        chk("sb_no_write_yet", RegWrite, 0);
        chk("sb_hazard_held", hazard1, 1);
        cyc();
        @(negedge clk);
        chk("sb_RegWrite", RegWrite, 1);
        chk("sb_WriteRegister", WriteRegister, 7);
        chk("sb_WriteData", WriteData, 32'h11);
        chk("sb_hazard_clear", hazard1, 0);

        // contention
        cyc();
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        alu_valid = 1; alu_rd = 10; alu_data = 32'h100;
        cyc();
        mem_valid = 0;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'(11 + i); alu_data = 32'h110 + i;
            @(negedge clk);
            chk("cont_no_stall", alu_stall, 0);
            cyc();
        end
        alu_rd = 15; alu_data = 32'h150;
        @(negedge clk);
        chk("cont_stall", alu_stall, 1);
        cyc();
        @(negedge clk);
        chk("cont_forced_rd", WriteRegister, 9);
        chk("cont_forced_data", WriteData, 32'h99);
        chk("cont_stall_released", alu_stall, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("cont_held_alu_rd", WriteRegister, 15);
        chk("cont_held_alu_data", WriteData, 32'h150);

        // full FIFO behind continuous ALU traffic
        idx = 0;
        saw_full = 0;
        for (int k = 0; k < 20; k++) begin
            alu_valid = 1; alu_rd = 5'(1 + k % 8); alu_data = 32'h200 + k;
            mem_valid = idx < 3;
            if (idx < 3) begin
                mem_rd = offers[idx].rd;
                mem_data = offers[idx].data;
            end
            #1;
            if (!mem_ready) saw_full = 1;
            acc = mem_valid && mem_ready;
            cyc();
            if (acc) idx++;
        end
        idle();
        chk("full_seen", saw_full, 1);
        chk("full_all_accepted", idx, 3);
        repeat (4) cyc();

        // rd=0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5555;
        cyc();
        idle();
        @(negedge clk);
        chk("rd0_alu_no_write", RegWrite, 0);
        mem_valid = 1; mem_rd = 0; mem_data = 32'h6666;
        iss_valid = 1; iss_rd = 0; rs1 = 0; rs2 = 0;
        cyc();
        idle();
        cyc();
        @(negedge clk);
        chk("rd0_mem_no_write", RegWrite, 0);
        chk("rd0_fifo_drained", mem_ready, 1);
        chk("rd0_no_busy", hazard1, 0);

        // same-cycle set and clear
        iss_valid = 1; iss_rd = 3;
        cyc();
        iss_valid = 0;
        mem_valid = 1; mem_rd = 3; mem_data = 32'h33;
        cyc();
        mem_valid = 0;
        iss_valid = 1; iss_rd = 3; rs2 = 3;
        cyc();
        idle();
        @(negedge clk);
        chk("setclr_write_rd", WriteRegister, 3);
        chk("setclr_busy_kept", hazard2, 1);

        // asynchronous reset with entries queued
        cyc();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        mem_valid = 1; mem_rd = 12; mem_data = 32'hC; iss_valid = 1; iss_rd = 12;
        cyc();
        mem_rd = 13; mem_data = 32'hD; iss_rd = 13;
        cyc();
        idle();
        rs1 = 12; rs2 = 13;
        #1;
        chk("pre_rst_full", mem_ready, 0);
        rst_n = 0;
        #1;
        chk("arst_mem_ready", mem_ready, 1);
        chk("arst_RegWrite", RegWrite, 0);
        chk("arst_hazard1", hazard1, 0);
        chk("arst_hazard2", hazard2, 0);
        cyc();
        rst_n = 1;
        repeat (3) cyc();
        @(negedge clk);
        chk("post_rst_no_write", RegWrite, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
